bsram_arbiter: RTL and testbench

- Shares one single-port 512x36 block RAM (`bsram_18k_36`) between N_REQ requesters, for example correlator channels and the acquisition engine.
- Arbitration is round-robin with a bounded burst: an owner keeps the port for up to MAX_BURST consecutive accesses while it holds its request.
- Drives the RAM address/data/write-enable/clock-enable pins and returns read data with a one-hot valid.

---
 rtl/bsram_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 32 +++
 rtl/bsram_arbiter.sv | 113 +++++++++++
 tb/tb_bsram_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsram_arb_pkg.sv
// Shared widths and the muxed memory command used by the block RAM arbiter.
// One 512x36 single-port block RAM addressed with a 5-bit zero pad below the word address.
package bsram_arb_pkg;

    localparam int BSRAM_AW       = 9;
    localparam int BSRAM_DW       = 36;
    localparam int BSRAM_AD_W     = 14;
    localparam int BSRAM_AD_SHIFT = 5;

    typedef struct packed {
        logic                we;
        logic [BSRAM_AW-1:0] addr;
        logic [BSRAM_DW-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
// Returns the one-hot grant, its index and whether anything was found.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] start_i,
    output logic [N_REQ-1:0]         onehot_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);

    localparam int IW = $clog2(N_REQ);

    int pos;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        pos      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(start_i) + k) % N_REQ;
            if (!valid_o && req_i[pos]) begin
                valid_o       = 1'b1;
                idx_o         = IW'(pos);
                onehot_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port block RAM between N_REQ requesters.
// Read data is broadcast one cycle after the grant edge and qualified by a one-hot rvalid.
module bsram_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    parameter int AW        = BSRAM_AW,
    parameter int DW        = BSRAM_DW
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*DW-1:0]   req_wdata,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      rvalid,
    output logic [DW-1:0]         rdata,
    output logic [BSRAM_AD_W-1:0] mem_ad,
    output logic [DW-1:0]         mem_di,
    output logic                  mem_wre,
    output logic                  mem_ce,
    input  logic [DW-1:0]         mem_do
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

    logic [IW-1:0]    owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;

    logic [IW-1:0]    start_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [N_REQ-1:0] owner_bit;
    logic             keep_owner;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    mem_cmd_t         cmd;

    assign start_idx = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req),
        .start_i  (start_idx),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // The owner stays while it requests, unless its burst is used up and someone else waits.
    // No access is accepted while reset is held.
    always_comb begin
        owner_bit  = N_REQ'(1) << owner_q;
        keep_owner = owner_valid_q && req[owner_q] &&
                     ((burst_q < BURST_LAST) || ((req & ~owner_bit) == '0));
        grant_idx  = keep_owner ? owner_q : pick_idx;
        grant_any  = !RESET && (keep_owner || pick_valid);
        grant      = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        cmd = '0;
        if (grant_any) begin
            cmd.we    = req_we[grant_idx];
            cmd.addr  = req_addr[int'(grant_idx)*AW +: AW];
            cmd.wdata = req_wdata[int'(grant_idx)*DW +: DW];
        end
    end

    assign mem_ad  = {cmd.addr, {BSRAM_AD_SHIFT{1'b0}}};
    assign mem_di  = cmd.wdata;
    assign mem_wre = cmd.we;
    assign mem_ce  = grant_any;
    assign rvalid  = rvalid_q;
    assign rdata   = mem_do;

    // An idle edge forgets the owner but keeps the pointer so the search resumes after it.
    always_comb begin
        owner_d       = owner_q;
        owner_valid_d = 1'b0;
        burst_d       = '0;
        rvalid_d      = grant & ~req_we;
        if (grant_any) begin
            owner_d       = grant_idx;
            owner_valid_d = 1'b1;
            if (owner_valid_q && (grant_idx == owner_q)) begin
                burst_d = (burst_q == BURST_LAST) ? BURST_LAST : burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            burst_q       <= '0;
            rvalid_q      <= '0;
        end else begin
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            burst_q       <= burst_d;
            rvalid_q      <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_bsram_arbiter.sv
// Self-checking bench for bsram_arbiter: directed scenarios plus random traffic against
// a behavioural arbitration/memory model and a behavioural block RAM.
module tb_bsram_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;
    localparam int AW = 9;
    localparam int DW = 36;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [13:0]     mem_ad;
    logic [DW-1:0]   mem_di;
    logic            mem_wre;
    logic            mem_ce;
    logic [DW-1:0]   mem_do;

    bsram_arbiter #(.N_REQ(N), .MAX_BURST(MB), .AW(AW), .DW(DW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .grant     (grant),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_ad    (mem_ad),
        .mem_di    (mem_di),
        .mem_wre   (mem_wre),
        .mem_ce    (mem_ce),
        .mem_do    (mem_do)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port block RAM: output holds on writes and disabled cycles.
    logic [DW-1:0] ram [512];
    logic [DW-1:0] ramDo = '0;
    assign mem_do = ramDo;
    always @(posedge CLK) begin
        if (mem_ce) begin
            if (mem_wre) ram[mem_ad[13:5]] <= mem_di;
            else         ramDo <= ram[mem_ad[13:5]];
        end
    end

    int testsRun = 0;
    int testsFailed = 0;

    logic [AW-1:0] tbAddr  [N];
    logic [DW-1:0] tbWdata [N];

    int            mOwner = 0;
    int            mRun = 0;
    bit            mActive = 0;
    logic [N-1:0]  expRvalid = '0;
    logic [DW-1:0] expRdata = '0;
    logic [DW-1:0] refMem [512];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Arbitration rule: keep a requesting owner unless its burst is spent and others wait,
    // otherwise the first requester after the owner going round; -1 means no grant.
    function automatic int modelPick(input logic [N-1:0] r);
        int others;
        others = 0;
        for (int i = 0; i < N; i++) if (i != mOwner && r[i]) others++;
        if (mActive && r[mOwner] && (mRun < MB - 1 || others == 0)) return mOwner;
        for (int k = 1; k <= N; k++) begin
            if (r[(mOwner + k) % N]) return (mOwner + k) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = 0;
        mRun = 0;
        mActive = 0;
        expRvalid = '0;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] w);
        int g;
        logic [N-1:0] expGrant;
        @(negedge CLK);
        req = r;
        req_we = w;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = tbAddr[i];
            req_wdata[i*DW +: DW] = tbWdata[i];
        end
        #1;
        checkOutput("rvalid", 64'(rvalid), 64'(expRvalid));
        if (expRvalid != '0) checkOutput("rdata", 64'(rdata), 64'(expRdata));
        g = modelPick(r);
        expGrant = (g >= 0) ? (N'(1) << g) : '0;
        checkOutput("grant", 64'(grant), 64'(expGrant));
        checkOutput("mem_ce", 64'(mem_ce), (g >= 0) ? 64'd1 : 64'd0);
        if (g >= 0) begin
            checkOutput("mem_ad", 64'(mem_ad), 64'(tbAddr[g]) * 64'd32);
            checkOutput("mem_wre", 64'(mem_wre), 64'(w[g]));
            checkOutput("mem_di", 64'(mem_di), 64'(tbWdata[g]));
            mRun = (mActive && g == mOwner) ? ((mRun + 1 > MB - 1) ? MB - 1 : mRun + 1) : 0;
            mOwner = g;
            mActive = 1;
            if (w[g]) begin
                refMem[tbAddr[g]] = tbWdata[g];
                expRvalid = '0;
            end else begin
                expRdata = refMem[tbAddr[g]];
                expRvalid = expGrant;
            end
        end else begin
            checkOutput("idle_ad", 64'(mem_ad), 64'd0);
            checkOutput("idle_wre", 64'(mem_wre), 64'd0);
            checkOutput("idle_di", 64'(mem_di), 64'd0);
            mActive = 0;
            mRun = 0;
            expRvalid = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i] = '0;
            refMem[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            tbAddr[i] = '0;
            tbWdata[i] = '0;
        end

        #1;
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("rst_ce", 64'(mem_ce), 64'd0);
        checkOutput("rst_wre", 64'(mem_wre), 64'd0);
        checkOutput("rst_ad", 64'(mem_ad), 64'd0);
        checkOutput("rst_di", 64'(mem_di), 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Single requester write then read-back of address 5.
        tbAddr[0] = 9'd5;
        tbWdata[0] = 36'h123456789;
        applyStimulus(4'b0001, 4'b0001);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Park the pointer on requester 3, then contend with all four for 40 cycles.
        applyStimulus(4'b1000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < N; j++) tbAddr[j] = 9'($urandom_range(0, 15));
            applyStimulus(4'b1111, 4'($urandom));
        end
        applyStimulus(4'b0000, 4'b0000);

        // Lone requester 2 streams 20 reads.
        for (int i = 0; i < 20; i++) begin
            tbAddr[2] = 9'(i);
            applyStimulus(4'b0100, 4'b0000);
        end

        // Owner 1 drops mid-burst while 3 and 0 wait.
        applyStimulus(4'b0010, 4'b0000);
        repeat (3) applyStimulus(4'b1011, 4'b0000);
        applyStimulus(4'b1001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Read-after-write between requesters on consecutive grants.
        tbAddr[0] = 9'd7;
        tbWdata[0] = 36'hA5A5_5A5A_C;
        tbAddr[1] = 9'd7;
        applyStimulus(4'b0001, 4'b0001);
        applyStimulus(4'b0010, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Asynchronous reset right after a read grant drops the pending response.
        applyStimulus(4'b0100, 4'b0000);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        modelReset();
        checkOutput("rstmid_rvalid", 64'(rvalid), 64'd0);
        checkOutput("rstmid_grant", 64'(grant), 64'd0);
        repeat (2) begin
            @(negedge CLK);
            #1;
            checkOutput("rsthold_grant", 64'(grant), 64'd0);
            checkOutput("rsthold_rvalid", 64'(rvalid), 64'd0);
            checkOutput("rsthold_ce", 64'(mem_ce), 64'd0);
        end
        req = '0;
        @(negedge CLK);
        RESET = 1'b0;
        applyStimulus(4'b0001, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) begin
                tbAddr[j]  = 9'($urandom_range(0, 7));
                tbWdata[j] = {4'($urandom), 32'($urandom)};
            end
            applyStimulus(4'($urandom), 4'($urandom));
        end
        applyStimulus(4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
